ps2_ascii_fifo: RTL and testbench

- Sits between PS2_Interface and the lcd writer.
- Consumes the raw PS/2 byte stream (key_data plus a one-cycle received strobe) and strips break and extended sequences.
- Tracks Shift state and translates make codes to ASCII.
- Buffers characters in a first-word-fall-through FIFO drained by a valid/ready handshake, so no keystroke is lost while the LCD is busy.

---
 rtl/ps2_ascii_fifo_if.sv | 41 ++++
 rtl/ps2_ascii_fifo.sv | 177 +++++++++++++++++
 tb/tb_ps2_ascii_fifo.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_ascii_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii_fifo_if
// Description : Signal bundle between the PS/2 byte source, the ASCII
//               decoder/FIFO and the character consumer (LCD writer).
//               slave  - decoder side: takes scan bytes and ready, drives
//                        the character stream and status.
//               master - environment side: drives scan bytes and ready.
//   key_data    [7:0]      scan-code byte
//   key_pressed            one-cycle strobe, key_data valid
//   ascii_out   [7:0]      FIFO head character (0 when empty)
//   ascii_valid            FIFO non-empty
//   ascii_ready            consumer accepts head this cycle
//   fifo_count  [ADDR_W:0] occupancy 0..DEPTH
//   overflow               sticky drop flag
//   last_scan   [7:0]      last raw byte received
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_ascii_fifo_if #(
    parameter int ADDR_W = 4
);
    logic [7:0]      key_data;
    logic            key_pressed;
    logic [7:0]      ascii_out;
    logic            ascii_valid;
    logic            ascii_ready;
    logic [ADDR_W:0] fifo_count;
    logic            overflow;
    logic [7:0]      last_scan;

    modport slave (
        input  key_data, key_pressed, ascii_ready,
        output ascii_out, ascii_valid, fifo_count, overflow, last_scan
    );

    modport master (
        output key_data, key_pressed, ascii_ready,
        input  ascii_out, ascii_valid, fifo_count, overflow, last_scan
    );
endinterface
`default_nettype wire

// File: rtl/ps2_ascii_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_ascii_fifo
// Description : Strips PS/2 set-2 break (F0) and extended (E0) sequences,
//               tracks Shift, translates make codes to ASCII and buffers the
//               characters in a first-word-fall-through FIFO drained by a
//               valid/ready handshake.
//   clock   - system clock
//   resetn  - asynchronous active-low reset
//   bus     - ps2_ascii_fifo_if.slave (scan input, character output, status)
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_ascii_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic         clock,
    input  wire logic         resetn,
    ps2_ascii_fifo_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BRK     = 2'd1,
        S_EXT     = 2'd2,
        S_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]      c_BRK_PREFIX = 8'hF0;
    localparam logic [7:0]      c_EXT_PREFIX = 8'hE0;
    localparam logic [7:0]      c_LSHIFT     = 8'h12;
    localparam logic [7:0]      c_RSHIFT     = 8'h59;
    localparam logic [ADDR_W:0] c_FULL       = (ADDR_W+1)'(DEPTH);

    state_t            r_state, w_state_next;
    logic              r_shift, w_shift_next;
    logic [7:0]        r_last_scan;
    logic              r_overflow;
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [7:0]        r_mem [DEPTH];

    logic              w_is_shift;
    logic              w_mapped;
    logic [7:0]        w_char;
    logic              w_push_req;
    logic              w_pop;
    logic              w_full;
    logic              w_do_push;

    assign w_is_shift = (bus.key_data == c_LSHIFT) || (bus.key_data == c_RSHIFT);

    // Make code -> ASCII. Letters are looked up in lowercase and shifted
    // down by 32 for uppercase; space, DEL and CR ignore Shift.
    always_comb begin
        w_mapped = 1'b1;
        w_char   = 8'h00;
        case (bus.key_data)
            8'h1C: w_char = 8'h61;  8'h32: w_char = 8'h62;
            8'h21: w_char = 8'h63;  8'h23: w_char = 8'h64;
            8'h24: w_char = 8'h65;  8'h2B: w_char = 8'h66;
            8'h34: w_char = 8'h67;  8'h33: w_char = 8'h68;
            8'h43: w_char = 8'h69;  8'h3B: w_char = 8'h6A;
            8'h42: w_char = 8'h6B;  8'h4B: w_char = 8'h6C;
            8'h3A: w_char = 8'h6D;  8'h31: w_char = 8'h6E;
            8'h44: w_char = 8'h6F;  8'h4D: w_char = 8'h70;
            8'h15: w_char = 8'h71;  8'h2D: w_char = 8'h72;
            8'h1B: w_char = 8'h73;  8'h2C: w_char = 8'h74;
            8'h3C: w_char = 8'h75;  8'h2A: w_char = 8'h76;
            8'h1D: w_char = 8'h77;  8'h22: w_char = 8'h78;
            8'h35: w_char = 8'h79;  8'h1A: w_char = 8'h7A;
            default: w_mapped = 1'b0;
        endcase
        if (w_mapped && r_shift) begin
            w_char = w_char - 8'd32;
        end
        case (bus.key_data)
            8'h29: begin w_mapped = 1'b1; w_char = 8'h20; end
            8'h66: begin w_mapped = 1'b1; w_char = 8'h7F; end
            8'h5A: begin w_mapped = 1'b1; w_char = 8'h0D; end
            default: ;
        endcase
    end

    // Decoder next state: only IDLE can produce a character.
    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_push_req   = 1'b0;
        if (bus.key_pressed) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.key_data == c_BRK_PREFIX) begin
                        w_state_next = S_BRK;
                    end else if (bus.key_data == c_EXT_PREFIX) begin
                        w_state_next = S_EXT;
                    end else if (w_is_shift) begin
                        w_shift_next = 1'b1;
                    end else begin
                        w_push_req = w_mapped;
                    end
                end
                S_BRK: begin
                    if (w_is_shift) begin
                        w_shift_next = 1'b0;
                    end
                    w_state_next = S_IDLE;
                end
                S_EXT: begin
                    w_state_next = (bus.key_data == c_BRK_PREFIX) ? S_EXT_BRK : S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_shift     <= 1'b0;
            r_last_scan <= 8'h00;
        end else begin
            r_state <= w_state_next;
            r_shift <= w_shift_next;
            if (bus.key_pressed) begin
                r_last_scan <= bus.key_data;
            end
        end
    end

    // FIFO control. A push into a full FIFO is still accepted when the head
    // leaves in the same cycle, since that frees the slot being written.
    assign w_full    = (r_count == c_FULL);
    assign w_pop     = bus.ascii_valid && bus.ascii_ready;
    assign w_do_push = w_push_req && (!w_full || w_pop);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_push_req && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_char;
        end
    end

    assign bus.ascii_valid = (r_count != '0);
    assign bus.ascii_out   = bus.ascii_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign bus.fifo_count  = r_count;
    assign bus.overflow    = r_overflow;
    assign bus.last_scan   = r_last_scan;

endmodule
`default_nettype wire

// File: tb/tb_ps2_ascii_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_ascii_fifo
// Description : Self-checking bench for ps2_ascii_fifo. Expected characters
//               are queued as scan bytes are driven and compared as the
//               consumer handshake removes them from the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_ascii_fifo;

    logic clock;
    logic resetn;

    ps2_ascii_fifo_if #(.ADDR_W(4)) bus ();

    ps2_ascii_fifo #(
        .DEPTH  (16),
        .ADDR_W (4)
    ) u_dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] sb [$];

    logic [7:0] c_codes [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer side: a transfer happens at the next rising edge whenever
    // valid and ready are both high at the falling edge.
    always @(negedge clock) begin
        if (resetn && bus.ascii_valid && bus.ascii_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_char", {24'h0, bus.ascii_out}, 32'hFFFF_FFFF);
            end else begin
                check("char", {24'h0, bus.ascii_out}, {24'h0, sb.pop_front()});
            end
        end
    end

    // Tasks are entered and left one time unit after a rising edge.
    task automatic send(input logic [7:0] b, input bit exp_push, input logic [7:0] exp_char);
        bus.key_data    = b;
        bus.key_pressed = 1'b1;
        if (exp_push) sb.push_back(exp_char);
        @(posedge clock); #1;
        bus.key_pressed = 1'b0;
    endtask

    task automatic drain();
        bus.ascii_ready = 1'b1;
        for (int k = 0; k < 100 && bus.fifo_count != 0; k++) begin
            @(posedge clock); #1;
        end
        bus.ascii_ready = 1'b0;
        check("drain_count", bus.fifo_count, 0);
        check("drain_sb_left", sb.size(), 0);
    endtask

    initial begin
        resetn          = 1'b0;
        bus.key_data    = 8'h00;
        bus.key_pressed = 1'b0;
        bus.ascii_ready = 1'b0;

        // Reset then idle
        repeat (3) @(posedge clock);
        #1 resetn = 1'b1;
        check("rst_out",   bus.ascii_out,   0);
        check("rst_valid", bus.ascii_valid, 0);
        check("rst_count", bus.fifo_count,  0);
        check("rst_ovf",   bus.overflow,    0);
        check("rst_scan",  bus.last_scan,   0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            check("idle_valid", bus.ascii_valid, 0);
        end

        // Make and break of a letter
        send(8'h1C, 1, 8'h61);
        send(8'hF0, 0, 8'h00);
        send(8'h1C, 0, 8'h00);
        check("mb_count", bus.fifo_count, 1);
        check("mb_out",   bus.ascii_out,  8'h61);
        check("mb_scan",  bus.last_scan,  8'h1C);
        bus.ascii_ready = 1'b1;
        @(posedge clock); #1;
        bus.ascii_ready = 1'b0;
        check("mb_pop_valid", bus.ascii_valid, 0);
        check("mb_pop_count", bus.fifo_count,  0);

        // Shift, then extended sequences and an unmapped code
        send(8'h12, 0, 8'h00);
        send(8'h33, 1, 8'h48);
        send(8'hF0, 0, 8'h00);
        send(8'h12, 0, 8'h00);
        send(8'h33, 1, 8'h68);
        check("sh_count", bus.fifo_count, 2);
        check("sh_head",  bus.ascii_out,  8'h48);
        send(8'hE0, 0, 8'h00);
        send(8'h75, 0, 8'h00);
        send(8'hE0, 0, 8'h00);
        send(8'hF0, 0, 8'h00);
        send(8'h75, 0, 8'h00);
        send(8'h0E, 0, 8'h00);
        check("ext_count", bus.fifo_count, 2);
        check("ext_scan",  bus.last_scan,  8'h0E);
        send(8'h29, 1, 8'h20);   // space proves the decoder is back in IDLE
        send(8'h5A, 1, 8'h0D);
        send(8'h66, 1, 8'h7F);
        check("ctl_count", bus.fifo_count, 5);
        drain();

        // Fill and overflow
        for (int i = 0; i < 17; i++) send(8'h1C, (i < 16), 8'h61);
        check("full_count", bus.fifo_count, 16);
        check("full_ovf",   bus.overflow,   1);
        check("full_head",  bus.ascii_out,  8'h61);
        bus.ascii_ready = 1'b1;
        send(8'h32, 1, 8'h62);
        bus.ascii_ready = 1'b0;
        check("full_pp_count", bus.fifo_count, 16);
        check("full_pp_ovf",   bus.overflow,   1);
        drain();

        // Pointer wrap with random consumer
        for (int i = 0; i < 80; i++) begin
            if (i % 2 == 0) begin
                bus.key_data    = c_codes[(i/2) % 26];
                bus.key_pressed = 1'b1;
                sb.push_back(8'(97 + (i/2) % 26));
            end else begin
                bus.key_pressed = 1'b0;
            end
            bus.ascii_ready = (bus.fifo_count >= 12) ? 1'b1 : 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            check("wrap_count_le16", (bus.fifo_count <= 16), 1);
        end
        bus.key_pressed = 1'b0;
        bus.ascii_ready = 1'b0;
        drain();

        // Reset mid-operation
        for (int i = 0; i < 5; i++) send(c_codes[i], 1, 8'(97 + i));
        check("pre_rst_count", bus.fifo_count, 5);
        send(8'hF0, 0, 8'h00);
        resetn = 1'b0;
        sb.delete();
        #1;
        check("mid_rst_count", bus.fifo_count, 0);
        check("mid_rst_valid", bus.ascii_valid, 0);
        check("mid_rst_ovf",   bus.overflow,   0);
        @(posedge clock); #1;
        resetn = 1'b1;
        send(8'h1C, 1, 8'h61);
        check("post_rst_count", bus.fifo_count, 1);
        check("post_rst_out",   bus.ascii_out,  8'h61);
        check("post_rst_ovf",   bus.overflow,   0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
